// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-requester round-robin arbiter in front of a single-outstanding SRAM port
module sram_arbiter #(
  parameter int RELEASE_CYCLES = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [2:0]  i_request,
  input  logic [2:0]  i_rw,
  input  logic [95:0] i_address,
  input  logic [95:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [2:0]  o_ready,
  output logic [2:0]  o_grant,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ready
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  // Release counter only needs to reach RELEASE_CYCLES-1.
  localparam int            CW     = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(RELEASE_CYCLES - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_count;
  logic [1:0]    r_last_grant;
  logic [2:0]    r_grant;
  logic [2:0]    r_ready;
  logic          r_bus_request;
  logic          r_bus_rw;
  logic [31:0]   r_bus_address;
  logic [31:0]   r_bus_wdata;
  logic [31:0]   r_rdata;

  logic [1:0]    w_first;
  logic [1:0]    w_second;
  logic [1:0]    w_third;
  logic [1:0]    w_winner;
  logic          w_any;

  function automatic logic [1:0] next_rr(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin pick: the requester after the last owner is looked at first.
  always_comb begin
    w_first  = next_rr(r_last_grant);
    w_second = next_rr(w_first);
    w_third  = next_rr(w_second);
    w_any    = |i_request;
    w_winner = w_third;
    if (i_request[w_first]) begin
      w_winner = w_first;
    end else if (i_request[w_second]) begin
      w_winner = w_second;
    end else begin
      w_winner = w_third;
    end
  end

  // Transaction FSM: grant and latch in IDLE, wait for the SRAM in BUSY, hold the bus idle in RELEASE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_last_grant  <= 2'd2;
      r_grant       <= 3'b000;
      r_ready       <= 3'b000;
      r_bus_request <= 1'b0;
      r_bus_rw      <= 1'b0;
      r_bus_address <= 32'd0;
      r_bus_wdata   <= 32'd0;
      r_rdata       <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state       <= S_BUSY;
            r_grant       <= 3'b001 << w_winner;
            r_last_grant  <= w_winner;
            r_bus_request <= 1'b1;
            r_bus_rw      <= i_rw[w_winner];
            r_bus_address <= i_address[{w_winner, 5'b00000} +: 32];
            r_bus_wdata   <= i_wdata[{w_winner, 5'b00000} +: 32];
          end
        end
        S_BUSY: begin
          if (i_bus_ready) begin
            r_state       <= S_RELEASE;
            r_bus_request <= 1'b0;
            r_ready       <= r_grant;
            r_count       <= '0;
            // Writes leave the last read word visible.
            if (!r_bus_rw) begin
              r_rdata <= i_bus_rdata;
            end
          end
        end
        S_RELEASE: begin
          r_ready <= 3'b000;
          if (r_count == C_LAST) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rdata       = r_rdata;
  assign o_ready       = r_ready;
  assign o_grant       = r_grant;
  assign o_bus_request = r_bus_request;
  assign o_bus_rw      = r_bus_rw;
  assign o_bus_address = r_bus_address;
  assign o_bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized and directed checks of sram_arbiter against a transaction-level model
module tb_sram_arbiter;

  localparam int RC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [2:0]  rw = 3'b000;
  logic [95:0] addr = '0;
  logic [95:0] wdata = '0;
  logic [31:0] bus_rdata = 32'd0;
  logic        bus_ready = 1'b0;

  logic [31:0] rdata;
  logic [2:0]  ready;
  logic [2:0]  grant;
  logic        bus_request;
  logic        bus_rw;
  logic [31:0] bus_address;
  logic [31:0] bus_wdata;

  always #5 clk = ~clk;

  sram_arbiter #(.RELEASE_CYCLES(RC)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_request     (req),
    .i_rw          (rw),
    .i_address     (addr),
    .i_wdata       (wdata),
    .o_rdata       (rdata),
    .o_ready       (ready),
    .o_grant       (grant),
    .o_bus_request (bus_request),
    .o_bus_rw      (bus_rw),
    .o_bus_address (bus_address),
    .o_bus_wdata   (bus_wdata),
    .i_bus_rdata   (bus_rdata),
    .i_bus_ready   (bus_ready)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the bus, whether its transfer is done, idle time left.
  int          m_owner;
  bit          m_done;
  int          m_cool;
  int          m_last;
  int          m_ready_idx;
  logic        m_rw;
  logic [31:0] m_addr, m_wdata, m_rdata;

  // Inputs as seen by the DUT at the edge being modelled.
  logic        p_rst, p_bus_ready;
  logic [2:0]  p_req, p_rw;
  logic [95:0] p_addr, p_wdata;
  logic [31:0] p_bus_rdata;

  // Downstream SRAM and requester agents.
  logic [31:0] mem [16];
  int          dn_cnt = 0;
  int          dn_lat = 8;
  int          dn_fixed = 8;
  bit          raise_en = 0;
  bit          spur_en = 0;

  logic [2:0]  prev_grant = 3'b000;
  logic [2:0]  g_q[$];
  int          low_run = 0;
  bit          had_prior = 0;

  task automatic model_edge();
    if (p_rst) begin
      m_owner = -1; m_done = 0; m_cool = 0; m_last = 2; m_ready_idx = -1;
      m_rw = 1'b0; m_addr = 32'd0; m_wdata = 32'd0; m_rdata = 32'd0;
    end else if (m_owner < 0) begin
      m_ready_idx = -1;
      for (int k = 1; k <= 3; k++) begin
        int c;
        c = (m_last + k) % 3;
        if (p_req[c]) begin
          m_owner = c; m_last = c; m_done = 0;
          m_rw = p_rw[c]; m_addr = p_addr[32*c +: 32]; m_wdata = p_wdata[32*c +: 32];
          break;
        end
      end
    end else if (!m_done) begin
      if (p_bus_ready) begin
        m_done = 1; m_ready_idx = m_owner; m_cool = RC;
        if (!m_rw) m_rdata = p_bus_rdata;
      end
    end else begin
      m_ready_idx = -1;
      m_cool--;
      if (m_cool == 0) m_owner = -1;
    end
  endtask

  task automatic step();
    logic [2:0] eg, er;
    p_rst = rst; p_req = req; p_rw = rw; p_addr = addr; p_wdata = wdata;
    p_bus_ready = bus_ready; p_bus_rdata = bus_rdata;
    @(posedge clk);
    #1;
    model_edge();
    eg = 3'b000; er = 3'b000;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_ready_idx >= 0) er[m_ready_idx] = 1'b1;
    check("grant", grant, eg);
    check("ready", ready, er);
    check("bus_request", bus_request, (m_owner >= 0 && !m_done));
    check("bus_rw", bus_rw, m_rw);
    check("bus_address", bus_address, m_addr);
    check("bus_wdata", bus_wdata, m_wdata);
    check("rdata", rdata, m_rdata);
    // Minimum idle spacing between two bus transactions.
    if (p_rst) had_prior = 0;
    if (bus_request) begin
      if (low_run > 0 && had_prior) check("gap", (low_run >= RC), 1'b1);
      low_run = 0;
      had_prior = 1;
    end else begin
      low_run++;
    end
    if (prev_grant == 3'b000 && grant != 3'b000) g_q.push_back(grant);
    prev_grant = grant;
    // Requesters: drop on completion, optionally wander.
    for (int n = 0; n < 3; n++) begin
      if (req[n] && ready[n]) begin
        req[n] = 1'b0;
      end else if (raise_en) begin
        if (req[n]) begin
          if ($urandom % 4 == 0) begin
            addr[32*n +: 32]  = 32'($urandom_range(0, 15)) << 2;
            wdata[32*n +: 32] = $urandom;
          end
          if ($urandom % 40 == 0) req[n] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req[n] = 1'b1;
          rw[n] = 1'($urandom % 2);
          addr[32*n +: 32]  = 32'($urandom_range(0, 15)) << 2;
          wdata[32*n +: 32] = $urandom;
        end
      end
    end
    // Downstream SRAM with fixed or random latency.
    bus_ready = 1'b0;
    if (bus_request) begin
      dn_cnt++;
      if (dn_cnt == 1) dn_lat = (dn_fixed != 0) ? dn_fixed : int'($urandom_range(1, 8));
      if (dn_cnt == dn_lat) begin
        bus_ready = 1'b1;
        if (bus_rw) begin
          mem[bus_address[5:2]] = bus_wdata;
          bus_rdata = $urandom;
        end else begin
          bus_rdata = mem[bus_address[5:2]];
        end
      end
    end else begin
      dn_cnt = 0;
      if (spur_en && ($urandom % 6 == 0)) begin
        bus_ready = 1'b1;
        bus_rdata = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    req = 3'b000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    g_q.delete();
  endtask

  task automatic wait_grants(input int n, input int budget);
    int b;
    b = budget;
    while (g_q.size() < n && b > 0) begin
      step();
      if (req[0] == 1'b0 && raise_en == 0 && n == 3 && rw == 3'b111) req[0] = 1'b1;
      b--;
    end
    check("grant_count", g_q.size(), n);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;

    // Reset state.
    do_reset();
    check("reset_grant", grant, 3'b000);
    check("reset_busreq", bus_request, 1'b0);

    // Spurious downstream completion while idle.
    bus_ready = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    step();
    check("spur_ready", ready, 3'b000);
    check("spur_rdata", rdata, 32'd0);

    // Single read by requester 1 with an 8-cycle downstream.
    mem[0] = 32'hDEAD_BEEF;
    dn_fixed = 8;
    rw[1] = 1'b0; addr[63:32] = 32'h100; req[1] = 1'b1;
    step();
    check("rd_grant", grant, 3'b010);
    k = 0;
    do begin step(); k++; end while (ready == 3'b000 && k < 20);
    check("rd_latency", k, 8);
    check("rd_ready", ready, 3'b010);
    check("rd_data", rdata, 32'hDEAD_BEEF);
    step();
    check("rd_ready_pulse", ready, 3'b000);

    // Write latching with inputs changing mid-transaction.
    do_reset();
    rw[2] = 1'b1; addr[95:64] = 32'h40; wdata[95:64] = 32'h1234_5678; req[2] = 1'b1;
    step();
    check("wr_grant", grant, 3'b100);
    k = 0;
    do begin
      step(); k++;
      if (k == 3) begin addr[95:64] = 32'h80; wdata[95:64] = 32'hAAAA_5555; end
      if (bus_request) begin
        check("wr_addr", bus_address, 32'h40);
        check("wr_data", bus_wdata, 32'h1234_5678);
      end
    end while (ready == 3'b000 && k < 20);
    check("wr_ready", ready, 3'b100);

    // Reset in the middle of a transaction.
    do_reset();
    rw[1] = 1'b0; req[1] = 1'b1;
    step();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busreq", bus_request, 1'b0);
    check("rst_ready", ready, 3'b000);
    req[0] = 1'b1;
    step();
    check("rst_regrant", grant, 3'b001);

    // Simultaneous requests after reset: served 0, 1, 2.
    do_reset();
    rw = 3'b000; req = 3'b111;
    wait_grants(3, 100);
    if (g_q.size() >= 3) begin
      check("order0", g_q[0], 3'b001);
      check("order1", g_q[1], 3'b010);
      check("order2", g_q[2], 3'b100);
    end

    // Fairness: requester 0 keeps asking, requester 2 asks once.
    do_reset();
    rw = 3'b000; req = 3'b001;
    step();
    req[2] = 1'b1;
    k = 0;
    while (g_q.size() < 3 && k < 80) begin
      step();
      if (!req[0]) req[0] = 1'b1;
      k++;
    end
    check("fair_count", g_q.size(), 3);
    if (g_q.size() >= 3) begin
      check("fair0", g_q[0], 3'b001);
      check("fair1", g_q[1], 3'b100);
      check("fair2", g_q[2], 3'b001);
    end

    // Randomized traffic with random latency, spurious completions and occasional resets.
    do_reset();
    raise_en = 1; spur_en = 1; dn_fixed = 0;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom % 250 == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
